// File: rtl/aud_i2s_recorder.sv
// I2S capture for the codec ADC path. Deserialises left-channel samples (MSB first, one
// BCLK after the falling LRC edge) and issues one SRAM write strobe per sample with a
// running word address. Controlled by record/pause/stop pulses from the top-level FSM.
module aud_i2s_recorder #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_len,
  output logic              o_busy,
  output logic              o_full
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StSkip,
    StShift,
    StPaused,
    StFull
  } state_e;

  state_e            r_state, w_state_nxt;
  logic              r_lrc_d;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_pend, w_pend_nxt;
  logic [ADDR_W-1:0] r_len, w_len_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_full, w_full_nxt;
  logic              w_fall;
  logic [DATA_W-1:0] w_shift_in;

  // Start of the left half frame: LRC seen low now, high on the previous edge.
  assign w_fall     = ~i_lrc & r_lrc_d;
  assign w_shift_in = {r_shift[DATA_W-2:0], i_data};

  // State and datapath registers; reset drops any partial sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_lrc_d <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_len   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lrc_d <= i_lrc;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_len   <= w_len_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_full  <= w_full_nxt;
    end
  end

  // Next-state logic; stop overrides everything, then pause, then start.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_len_nxt   = r_len;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_full_nxt  = r_full;

    if (i_stop) begin
      // Committed length is kept so playback knows where the recording ends.
      w_state_nxt = StIdle;
      w_pend_nxt  = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        StIdle, StFull: begin
          if (i_start) begin
            w_state_nxt = StWait;
            w_len_nxt   = '0;
            w_addr_nxt  = '0;
            w_full_nxt  = 1'b0;
          end
        end
        StPaused: begin
          if (i_start) begin
            w_state_nxt = StWait;
          end
        end
        StWait: begin
          if (i_pause) begin
            w_state_nxt = StPaused;
          end else if (w_fall) begin
            // This edge carries the I2S delay bit; sampling begins on the next one.
            w_state_nxt = StSkip;
          end
        end
        StSkip: begin
          w_pend_nxt  = r_pend | i_pause;
          w_shift_nxt = w_shift_in;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = StShift;
        end
        StShift: begin
          w_pend_nxt  = r_pend | i_pause;
          w_shift_nxt = w_shift_in;
          if (r_cnt == LAST_BIT) begin
            w_data_nxt  = w_shift_in;
            w_addr_nxt  = r_len;
            w_valid_nxt = 1'b1;
            w_len_nxt   = r_len + ADDR_W'(1);
            w_cnt_nxt   = '0;
            w_pend_nxt  = 1'b0;
            if (r_len == MAX_ADDR) begin
              w_state_nxt = StFull;
              w_full_nxt  = 1'b1;
            end else if (r_pend || i_pause) begin
              w_state_nxt = StPaused;
            end else begin
              w_state_nxt = StWait;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  assign o_address = r_addr;
  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_len     = r_len;
  assign o_full    = r_full;
  assign o_busy    = (r_state == StWait) || (r_state == StSkip) || (r_state == StShift);

endmodule

// File: tb/tb_aud_i2s_recorder.sv
// Self-checking bench for aud_i2s_recorder: frames are driven bit by bit, each expected
// write strobe is queued with its cycle, address and data, and a monitor pops and compares.
module tb_aud_i2s_recorder;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 20;
  localparam int          HALF   = 20;  // BCLK cycles per LRC half frame

  logic              i_clk;
  logic              i_rst_n;
  logic              i_lrc;
  logic              i_data;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic [ADDR_W-1:0] o_len;
  logic              o_busy;
  logic              o_full;

  aud_i2s_recorder #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .MAX_ADDR(20'd3)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_lrc    (i_lrc),
    .i_data   (i_data),
    .i_start  (i_start),
    .i_pause  (i_pause),
    .i_stop   (i_stop),
    .o_address(o_address),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_len    (o_len),
    .o_busy   (o_busy),
    .o_full   (o_full)
  );

  typedef struct {
    int unsigned       cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_errors;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard, on the predicted cycle.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(posedge i_clk);
      cyc++;
      #1;
      if (o_valid) begin
        check("valid_gap", {63'd0, prev_valid}, 64'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_valid", {63'd0, o_valid}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("strobe_cycle", 64'(cyc), 64'(e.cyc));
          check("strobe_addr", 64'(o_address), 64'(e.addr));
          check("strobe_data", 64'(o_data), 64'(e.data));
        end
      end
      prev_valid = o_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge i_clk);
    i_start = 1'b1;
    i_pause = 1'b0;
    i_stop  = 1'b0;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge i_clk);
    i_stop = 1'b1;
    @(negedge i_clk);
    i_stop = 1'b0;
  endtask

  // One LRC frame. Left word on k=1..16, delay bit k=0 is a decoy. Optional pause/stop
  // pulse or async reset at left-half cycle k; exp queues a strobe for edge n+16.
  task automatic send_frame(input logic [DATA_W-1:0] lw, input logic [DATA_W-1:0] rw,
                            input bit exp, input logic [ADDR_W-1:0] ea,
                            input int pause_k, input int stop_k, input int rst_k);
    logic [DATA_W-1:0] w;
    exp_t e;
    for (int half = 0; half < 2; half++) begin
      w = (half == 0) ? lw : rw;
      for (int k = 0; k < HALF; k++) begin
        @(negedge i_clk);
        i_lrc   = (half == 1);
        i_pause = (half == 0) && (k == pause_k);
        i_stop  = (half == 0) && (k == stop_k);
        if (k == 0) i_data = (half == 0) ? 1'b1 : ~lw[0];
        else if (k <= 16) i_data = w[16-k];
        else i_data = 1'($urandom_range(0, 1));
        if (exp && half == 0 && k == 16) begin
          e.cyc  = cyc + 1;
          e.addr = ea;
          e.data = lw;
          sb_q.push_back(e);
        end
        if (half == 0 && k == rst_k) begin
          i_rst_n = 1'b0;
          #1;
          check("rst_valid", 64'(o_valid), 64'd0);
          check("rst_addr", 64'(o_address), 64'd0);
          check("rst_data", 64'(o_data), 64'd0);
          check("rst_len", 64'(o_len), 64'd0);
          check("rst_busy", 64'(o_busy), 64'd0);
          check("rst_full", 64'(o_full), 64'd0);
        end
        if (half == 0 && k == rst_k + 2) i_rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    i_rst_n  = 1'b0;
    i_lrc    = 1'b1;
    i_data   = 1'b0;
    i_start  = 1'b0;
    i_pause  = 1'b0;
    i_stop   = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_addr", 64'(o_address), 64'd0);
    check("reset_data", 64'(o_data), 64'd0);
    check("reset_len", 64'(o_len), 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_full", 64'(o_full), 64'd0);
    i_rst_n = 1'b1;

    // Idle: frames must not be captured.
    send_frame(16'h1234, 16'h4321, 1'b0, '0, -1, -1, -1);

    // Basic capture with a right-channel word that must be ignored.
    pulse_start();
    check("busy_after_start", 64'(o_busy), 64'd1);
    send_frame(16'hA5C3, 16'hFFFF, 1'b1, 20'd0, -1, -1, -1);
    check("len_one", 64'(o_len), 64'd1);

    // Three consecutive frames from a fresh start.
    pulse_stop();
    pulse_start();
    check("len_cleared", 64'(o_len), 64'd0);
    send_frame(16'h0001, 16'h5555, 1'b1, 20'd0, -1, -1, -1);
    send_frame(16'h8000, 16'hAAAA, 1'b1, 20'd1, -1, -1, -1);
    send_frame(16'h7FFF, 16'h0000, 1'b1, 20'd2, -1, -1, -1);
    check("len_three", 64'(o_len), 64'd3);

    // Pause mid-word: word in flight commits, then nothing until resume.
    pulse_stop();
    pulse_start();
    send_frame(16'h1357, 16'h0F0F, 1'b1, 20'd0, -1, -1, -1);
    send_frame(16'h2468, 16'hF0F0, 1'b1, 20'd1, 8, -1, -1);
    check("paused_busy", 64'(o_busy), 64'd0);
    send_frame(16'hDEAD, 16'hBEEF, 1'b0, '0, -1, -1, -1);
    check("paused_len", 64'(o_len), 64'd2);
    pulse_start();
    send_frame(16'hC0DE, 16'h1111, 1'b1, 20'd2, -1, -1, -1);
    check("resume_len", 64'(o_len), 64'd3);

    // Stop mid-word: partial word dropped, committed length kept.
    send_frame(16'h6666, 16'h7777, 1'b0, '0, -1, 10, -1);
    check("stop_busy", 64'(o_busy), 64'd0);
    check("stop_len", 64'(o_len), 64'd3);
    pulse_start();
    send_frame(16'h9ABC, 16'h2222, 1'b1, 20'd0, -1, -1, -1);
    check("restart_len", 64'(o_len), 64'd1);

    // Saturation at MAX_ADDR = 3.
    pulse_stop();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      send_frame(16'(16'h1111 * (i + 1)), 16'h3333, (i < 4), ADDR_W'(i), -1, -1, -1);
    end
    check("full_flag", 64'(o_full), 64'd1);
    check("full_busy", 64'(o_busy), 64'd0);
    check("full_len", 64'(o_len), 64'd4);
    pulse_start();
    check("full_cleared", 64'(o_full), 64'd0);
    send_frame(16'hFACE, 16'h4444, 1'b1, 20'd0, -1, -1, -1);

    // Async reset during SHIFT: outputs clear, no capture until a new start.
    send_frame(16'hB00B, 16'h5555, 1'b0, '0, -1, -1, 8);
    send_frame(16'hCAFE, 16'h6666, 1'b0, '0, -1, -1, -1);
    pulse_start();
    send_frame(16'h0F1E, 16'h7777, 1'b1, 20'd0, -1, -1, -1);
    check("post_reset_len", 64'(o_len), 64'd1);

    repeat (4) @(negedge i_clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aud_i2s_recorder.md
Name: aud_i2s_recorder

Overview:
- I2S receive side of the codec audio path, the capture counterpart of the DAC-side player.
- Deserialises left-channel ADC samples from the WM8731 and emits one SRAM write strobe per sample, with a running address.
- Sits inside Top between the codec pins (AUD_ADCDAT, AUD_ADCLRCK, AUD_BCLK) and the SRAM write mux.
- Driven by record/pause/stop pulses from the Top control FSM.

Parameters:
DATA_W, 16, sample width in bits
ADDR_W, 20, SRAM word-address width
MAX_ADDR, 20'hFFFFF, last writable address; recording saturates here

Ports:
i_clk  input  1  bit clock (AUD_BCLK); all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_lrc  input  1  AUD_ADCLRCK; low = left channel
i_data  input  1  AUD_ADCDAT serial data
i_start  input  1  one-cycle pulse: start (from IDLE/FULL) or resume (from PAUSED)
i_pause  input  1  one-cycle pulse: pause after current word
i_stop  input  1  one-cycle pulse: abort and stop
o_address  output  ADDR_W  SRAM address of o_data
o_data  output  DATA_W  captured sample, two's complement, MSB first on the wire
o_valid  output  1  one-cycle write strobe; o_address/o_data valid while high
o_len  output  ADDR_W  number of samples committed since last fresh start
o_busy  output  1  high in WAIT, SKIP, SHIFT
o_full  output  1  high once MAX_ADDR has been written

Behaviour:
- Reset (async): state IDLE; o_address=0, o_data=0, o_valid=0, o_len=0, o_busy=0, o_full=0; shift register, bit counter and lrc_d cleared. Reset mid-word discards the partial sample.
- lrc_d is i_lrc registered every cycle. Falling-LRC event F at edge n: i_lrc=0 and lrc_d=1.
- States:
  - IDLE --i_start--> WAIT; o_len and o_address cleared; o_full cleared.
  - WAIT --F--> SKIP. Edge n is the I2S delay bit and is not sampled. F on the same edge as the i_start that entered WAIT does not qualify; capture starts at the next F.
  - SKIP --> SHIFT. Edges n+1..n+16 shift i_data into the LSB, so the MSB is first.
  - SHIFT: after the 16th bit, at edge n+16:
    - o_data <= full word (including the LSB sampled at that edge).
    - o_address <= o_len; o_valid=1 for exactly one cycle.
    - o_len <= o_len+1.
    - Next state is WAIT, or PAUSED if a pause is pending, or FULL if o_len was MAX_ADDR.
  - Right-channel half frames are ignored. Bits after the 16th within the left half are ignored.
  - PAUSED --i_start--> WAIT. o_len and o_address are kept; the next write goes to o_len.
  - FULL: o_full=1, o_busy=0. i_start behaves as from IDLE (restart at 0). o_len holds MAX_ADDR+1 truncated to ADDR_W, i.e. 0 with o_full=1 for the default parameters.
- Pause rules:
  - i_pause in WAIT goes to PAUSED immediately.
  - i_pause in SKIP/SHIFT sets a pending flag. The word in flight completes and commits, then the block goes to PAUSED.
- Stop rules:
  - i_stop in any state goes to IDLE next edge and clears the pending pause.
  - A partial word is discarded with no o_valid. o_len keeps its committed count for playback end-address. o_full is unchanged.
- Simultaneous pulses: priority stop > pause > start. i_start in WAIT/SKIP/SHIFT is ignored. i_pause in IDLE/PAUSED/FULL is ignored.
- o_valid is never high on two consecutive cycles. Minimum spacing is one LRC frame.

Test Plan:
- Reset, i_start, then a left word 16'hA5C3 sent MSB first after a falling LRC (delay bit = 1 as a decoy) -> at edge n+16 o_valid=1, o_data=16'hA5C3, o_address=0; o_len=1 afterwards; the right-channel word 16'hFFFF produces no strobe.
- Three frames with words 16'h0001, 16'h8000, 16'h7FFF -> three single-cycle strobes with o_address 0,1,2 and matching data; o_len=3.
- i_pause at edge n+8 of the second word -> the second word still commits at address 1; no strobe on the next frame; i_start, then the next word commits at address 2.
- i_stop at edge n+10 -> no strobe, state IDLE, o_len keeps its prior count; a fresh i_start then writes address 0 with o_len reset.
- MAX_ADDR overridden to 3; record 5 frames -> strobes at addresses 0..3 only; o_full=1, o_busy=0; i_start clears o_full and the next write goes to address 0.
- Async reset asserted mid-SHIFT -> all outputs 0 immediately; no strobe after release until a new i_start plus falling LRC.
